pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline with data cache. Merges the ID-stage data hazard, EXE-stage taken branch and MEM-stage cache wait into the freeze/flush controls of the PC register, the IF/ID register and the downstream pipeline registers. A bounded-wait FSM guards the memory stall and latches a sticky error if the cache never answers. Optional performance counters report stall and flush activity.

## Interface
- MEM_TIMEOUT, 1024: max MEM_WAIT cycles before error; 0 = timeout disabled
- CNT_W, 32: width of each performance counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- hazard_i  in  1  ID-stage data hazard (combinational from hazard unit)
- branch_taken_i  in  1  EXE-stage branch resolved taken
- mem_req_i  in  1  MEM stage holds a valid load/store
- mem_ready_i  in  1  cache/SRAM controller completes access this cycle
- freeze_pc_o  out  1  hold PC
- freeze_if_o  out  1  hold IF/ID register
- flush_if_o  out  1  clear IF/ID register (priority over freeze in that register)
- flush_id_o  out  1  clear ID/EXE register (bubble)
- freeze_back_o  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- mem_err_o  out  1  sticky memory-timeout error
- stall_cyc_o  out  CNT_W  cycles spent in memory stall (macro only)
- br_flush_o  out  CNT_W  branch flushes taken (macro only)
- hz_bubble_o  out  CNT_W  hazard bubbles inserted (macro only)

## Operation
- States: RUN, MEM_WAIT, ERR. Reset state RUN, wait_cnt = 0, mem_err_o = 0, all counters 0.
- mem_stall = (RUN & mem_req_i & ~mem_ready_i) | (MEM_WAIT & ~mem_ready_i) | ERR.
- Priority: mem_stall > branch_taken_i > hazard_i.
- mem_stall: freeze_pc, freeze_if, freeze_back = 1; flush_if, flush_id = 0 (flush must never coincide with freeze, else IF/ID loses held instruction).
- Branch (no mem_stall): flush_if = 1, flush_id = 1, freeze_* = 0; PC loads target. Hazard in same cycle ignored (instruction is flushed).
- Hazard (no mem_stall, no branch): freeze_pc = 1, freeze_if = 1, flush_id = 1, freeze_back = 0.
- Otherwise all outputs 0.
- Transitions: RUN -> MEM_WAIT when mem_req_i & ~mem_ready_i (wait_cnt <= 1). MEM_WAIT -> RUN when mem_ready_i (wait_cnt <= 0). MEM_WAIT: wait_cnt increments; when wait_cnt == MEM_TIMEOUT & ~mem_ready_i -> ERR (only if MEM_TIMEOUT != 0). ERR is terminal until rst; mem_err_o = 1 in ERR.
- mem_ready_i with mem_req_i in RUN: single-cycle hit, no stall, stay RUN.
- wait_cnt width clog2(MEM_TIMEOUT+1), min 1; never wraps (ERR reached first, or held at max when timeout disabled).

## Timing
- All freeze/flush outputs Mealy, combinational from state and inputs: zero-cycle latency, stall applies in the cycle the condition is seen.
- mem_ready_i releases freeze in the same cycle it is asserted; pipeline advances on that edge.
- Hazard bubble lasts exactly as long as hazard_i is high; controller adds no extra cycle.
- rst mid-stall: immediate return to RUN, outputs follow inputs as in RUN, mem_err_o cleared, counters cleared.
- Timeout: with MEM_TIMEOUT = N, ERR entered on edge ending the (N+1)th stalled cycle of one access.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: three CNT_W counters, increment by 1 per cycle of mem_stall (stall_cyc), per cycle with branch flush (br_flush), per cycle with hazard bubble (hz_bubble); wrap modulo 2^CNT_W.
- Undefined: counters not built, the three outputs tied to 0; control behaviour identical.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, ERR), default CNT_W, MEM_TIMEOUT default constant.
- Sub-module pipe_hazard_perf: counter bank with three increment strobes, instantiated only under the macro.

## Test plan
- hazard_i = 1 for 2 cycles, no mem_req -> freeze_pc = freeze_if = flush_id = 1 for exactly 2 cycles, freeze_back = 0.
- branch_taken_i and hazard_i both 1 for 1 cycle -> flush_if = flush_id = 1, freeze_pc = freeze_if = 0; hz_bubble unchanged, br_flush +1.
- mem_req_i = 1, mem_ready_i low 5 cycles then high -> freeze_* = 1 for 5 cycles, 0 in ready cycle; state RUN after; stall_cyc = 5.
- mem stall concurrent with branch_taken_i = 1 -> flush_if = flush_id = 0 throughout stall; flush asserted first cycle after ready.
- MEM_TIMEOUT = 4, mem_ready_i never asserted -> mem_err_o = 1 after 5 stalled cycles, freeze held; rst -> mem_err_o = 0, state RUN.
- Counters preset near 2^CNT_W-1 (CNT_W = 4 build) -> wrap to 0 on next increment.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default parameters for the hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  localparam int CNT_W_DEF = 32;
  localparam int MEM_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs, pipeline freeze/flush controls and perf counters
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic hazard_i;
  logic branch_taken_i;
  logic mem_req_i;
  logic mem_ready_i;
  logic freeze_pc_o;
  logic freeze_if_o;
  logic flush_if_o;
  logic flush_id_o;
  logic freeze_back_o;
  logic mem_err_o;
  logic [CNT_W-1:0] stall_cyc_o;
  logic [CNT_W-1:0] br_flush_o;
  logic [CNT_W-1:0] hz_bubble_o;
  modport master (
    output hazard_i, branch_taken_i, mem_req_i, mem_ready_i,
    input  freeze_pc_o, freeze_if_o, flush_if_o, flush_id_o, freeze_back_o, mem_err_o,
    input  stall_cyc_o, br_flush_o, hz_bubble_o
  );
  modport slave (
    input  hazard_i, branch_taken_i, mem_req_i, mem_ready_i,
    output freeze_pc_o, freeze_if_o, flush_if_o, flush_id_o, freeze_back_o, mem_err_o,
    output stall_cyc_o, br_flush_o, hz_bubble_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf.sv
// pipe_hazard_perf: three wrapping event counters for stall, branch flush and hazard bubble cycles
module pipe_hazard_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_stall,
  input  logic             inc_br,
  input  logic             inc_hz,
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] br_flush,
  output logic [CNT_W-1:0] hz_bubble
);
  // count one per strobed cycle, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cyc <= '0;
      br_flush  <= '0;
      hz_bubble <= '0;
    end else begin
      stall_cyc <= stall_cyc + CNT_W'(inc_stall);
      br_flush  <= br_flush + CNT_W'(inc_br);
      hz_bubble <= hz_bubble + CNT_W'(inc_hz);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges hazard/branch/cache-wait into pipeline freeze/flush; perf counters under PIPE_HAZARD_CTRL_PERF_EN
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WC_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_err;
  logic            mem_stall;
  logic            br_flush;
  logic            hz_bubble;
  assign mem_stall = (state == RUN && bus.mem_req_i && !bus.mem_ready_i) ||
                     (state == MEM_WAIT && !bus.mem_ready_i) || state == ERR;
  assign br_flush  = !mem_stall && bus.branch_taken_i;
  assign hz_bubble = !mem_stall && !bus.branch_taken_i && bus.hazard_i;
  assign bus.freeze_pc_o   = mem_stall || hz_bubble;
  assign bus.freeze_if_o   = mem_stall || hz_bubble;
  assign bus.flush_if_o    = br_flush;
  assign bus.flush_id_o    = br_flush || hz_bubble;
  assign bus.freeze_back_o = mem_stall;
  assign bus.mem_err_o     = mem_err;
  // bounded cache wait: count stalled cycles and trap into a sticky error on timeout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN:
          if (bus.mem_req_i && !bus.mem_ready_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        MEM_WAIT:
          if (bus.mem_ready_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (MEM_TIMEOUT != 0 && wait_cnt == WC_W'(MEM_TIMEOUT)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        default: begin
          state   <= ERR;
          mem_err <= 1'b1;
        end
      endcase
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  pipe_hazard_perf #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst       (rst),
    .inc_stall (mem_stall),
    .inc_br    (br_flush),
    .inc_hz    (hz_bubble),
    .stall_cyc (bus.stall_cyc_o),
    .br_flush  (bus.br_flush_o),
    .hz_bubble (bus.hz_bubble_o)
  );
`else
  assign bus.stall_cyc_o = '0;
  assign bus.br_flush_o  = '0;
  assign bus.hz_bubble_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scenario tasks with a scoreboard of expected control vectors
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int CW = 4;
  localparam int TO = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef logic [5:0] ovec_t;
  localparam ovec_t NONE = 6'b000000;
  localparam ovec_t HZ   = 6'b110100;
  localparam ovec_t BR   = 6'b001100;
  localparam ovec_t ST   = 6'b110010;
  localparam ovec_t ER   = 6'b110011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  ovec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] e_stall = '0;
  logic [CW-1:0] e_br = '0;
  logic [CW-1:0] e_hz = '0;
  ovec_t obs;
  logic [3*CW-1:0] cnt;
  assign obs = {bus.freeze_pc_o, bus.freeze_if_o, bus.flush_if_o, bus.flush_id_o,
                bus.freeze_back_o, bus.mem_err_o};
  assign cnt = {bus.stall_cyc_o, bus.br_flush_o, bus.hz_bubble_o};
  function automatic logic [3*CW-1:0] exp_cnt();
    return PERF ? {e_stall, e_br, e_hz} : '0;
  endfunction
  // in = {hazard, branch_taken, mem_req, mem_ready}
  task automatic apply(input logic [3:0] in, input ovec_t exp);
    @(posedge clk);
    #1;
    {bus.hazard_i, bus.branch_taken_i, bus.mem_req_i, bus.mem_ready_i} = in;
    sb.push_back(exp);
    @(negedge clk);
  endtask
  task automatic test_reset();
    ovec_t want;
    {bus.hazard_i, bus.branch_taken_i, bus.mem_req_i, bus.mem_ready_i} = 4'b0010;
    sb.push_back(ST);
    #3;
    want = sb.pop_front();
    n_cmp++;
    if (obs !== want) begin n_bad++; $display("FAIL reset_stall got %b want %b", obs, want); end
    {bus.hazard_i, bus.branch_taken_i, bus.mem_req_i, bus.mem_ready_i} = 4'b0000;
    sb.push_back(NONE);
    #1;
    want = sb.pop_front();
    n_cmp++;
    if (obs !== want) begin n_bad++; $display("FAIL reset_idle got %b want %b", obs, want); end
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL reset_cnt got %h want %h", cnt, exp_cnt()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_hazard();
    logic [3:0] st[3] = '{4'b1000, 4'b1000, 4'b0000};
    ovec_t ex[3] = '{HZ, HZ, NONE};
    ovec_t want;
    for (int i = 0; i < 3; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL hazard[%0d] got %b want %b", i, obs, want); end
    end
    e_hz += 2;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL hazard_cnt got %h want %h", cnt, exp_cnt()); end
  endtask
  task automatic test_branch();
    logic [3:0] st[2] = '{4'b1100, 4'b0000};
    ovec_t ex[2] = '{BR, NONE};
    ovec_t want;
    for (int i = 0; i < 2; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL branch[%0d] got %b want %b", i, obs, want); end
    end
    e_br += 1;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL branch_cnt got %h want %h", cnt, exp_cnt()); end
  endtask
  task automatic test_mem_stall();
    logic [3:0] st[7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b1000, 4'b0000};
    ovec_t ex[7] = '{ST, ST, ST, ST, NONE, HZ, NONE};
    ovec_t want;
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL mem_stall[%0d] got %b want %b", i, obs, want); end
    end
    e_stall += 4;
    e_hz += 1;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL mem_stall_cnt got %h want %h", cnt, exp_cnt()); end
  endtask
  task automatic test_stall_branch();
    logic [3:0] st[5] = '{4'b0110, 4'b0110, 4'b0110, 4'b0111, 4'b0000};
    ovec_t ex[5] = '{ST, ST, ST, BR, NONE};
    ovec_t want;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL stall_branch[%0d] got %b want %b", i, obs, want); end
    end
    e_stall += 3;
    e_br += 1;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL stall_branch_cnt got %h want %h", cnt, exp_cnt()); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] st[7] = '{4'b0100, 4'b1000, 4'b0010, 4'b0011, 4'b0011, 4'b1000, 4'b0000};
    ovec_t ex[7] = '{BR, HZ, ST, NONE, NONE, HZ, NONE};
    ovec_t want;
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL back_to_back[%0d] got %b want %b", i, obs, want); end
    end
    e_br += 1;
    e_hz += 2;
    e_stall += 1;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL back_to_back_cnt got %h want %h", cnt, exp_cnt()); end
  endtask
  task automatic test_timeout();
    logic [3:0] st[7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1111};
    ovec_t ex[7] = '{ST, ST, ST, ST, ST, ER, ER};
    ovec_t want;
    for (int i = 0; i < 7; i++) begin
      apply(st[i], ex[i]);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL timeout[%0d] got %b want %b", i, obs, want); end
    end
    e_stall += 6;
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL timeout_cnt got %h want %h", cnt, exp_cnt()); end
    rst = 1'b1;
    {bus.hazard_i, bus.branch_taken_i, bus.mem_req_i, bus.mem_ready_i} = 4'b0100;
    sb.push_back(BR);
    e_stall = '0;
    e_br = '0;
    e_hz = '0;
    #1;
    want = sb.pop_front();
    n_cmp++;
    if (obs !== want) begin n_bad++; $display("FAIL timeout_rst got %b want %b", obs, want); end
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL timeout_rst_cnt got %h want %h", cnt, exp_cnt()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    {bus.hazard_i, bus.branch_taken_i, bus.mem_req_i, bus.mem_ready_i} = 4'b0000;
    apply(4'b1000, HZ);
    want = sb.pop_front();
    n_cmp++;
    if (obs !== want) begin n_bad++; $display("FAIL timeout_run got %b want %b", obs, want); end
    e_hz += 1;
  endtask
  task automatic test_wrap();
    ovec_t want;
    for (int i = 1; i < 15; i++) begin
      apply(4'b1000, HZ);
      want = sb.pop_front();
      n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL wrap[%0d] got %b want %b", i, obs, want); end
      e_hz += 1;
    end
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL wrap_max got %h want %h", cnt, exp_cnt()); end
    apply(4'b1000, HZ);
    void'(sb.pop_front());
    e_hz += 1;
    apply(4'b0000, NONE);
    void'(sb.pop_front());
    n_cmp++;
    if (cnt !== exp_cnt()) begin n_bad++; $display("FAIL wrap_zero got %h want %h", cnt, exp_cnt()); end
  endtask
  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_mem_stall();
    test_stall_branch();
    test_back_to_back();
    test_timeout();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
